// File: rtl/nn_l1_sequencer_if.sv
// Handshake bundle between the layer-1 sequencer, its register front-end and the NN datapath.
// The controller side (register slave + datapath) drives through master; the sequencer uses slave.
interface nn_l1_sequencer_if #(
  parameter int N_IN   = 784,
  parameter int ADDR_W = 16,
  parameter int NIDX_W = 6
);
  logic              start;
  logic              abort;
  logic [N_IN-1:0]   features;
  logic              busy;
  logic              done;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic              acc_clr;
  logic              acc_en;
  logic [NIDX_W-1:0] acc_idx;
  logic              post_start;
  logic              post_done;

  modport master (
    output start, abort, features, post_done,
    input  busy, done, w_rd_en, w_addr, acc_clr, acc_en, acc_idx, post_start
  );

  modport slave (
    input  start, abort, features, post_done,
    output busy, done, w_rd_en, w_addr, acc_clr, acc_en, acc_idx, post_start
  );
endinterface

// File: rtl/nn_l1_sequencer.sv
// Bit-serial layer-1 sequencer: walks the weight BRAM linearly and issues accumulate strobes
// one cycle behind each read, then launches the post stage and reports completion.
//
// state | meaning
// IDLE  | waiting for start; features latched on acceptance
// CLEAR | one-cycle clear of all accumulators
// RUN   | one weight read per cycle, address 0 .. N_IN*N_HID-1
// DRAIN | no read; carries the last delayed accumulate strobe
// POST  | post_start on entry, wait for post_done
// DONE  | one-cycle done pulse
module nn_l1_sequencer #(
  parameter int N_IN   = 784,
  parameter int N_HID  = 64,
  parameter int ADDR_W = 16,
  parameter int NIDX_W = 6
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  nn_l1_sequencer_if.slave bus
);

  localparam int K_W = $clog2(N_IN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN * N_HID - 1);
  localparam logic [K_W-1:0]    K_LAST    = K_W'(N_IN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    POST  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [N_IN-1:0]   feat;
  logic [K_W-1:0]    k;
  logic [NIDX_W-1:0] neuron;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state          <= IDLE;
      feat           <= '0;
      k              <= '0;
      neuron         <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.w_rd_en    <= 1'b0;
      bus.w_addr     <= '0;
      bus.acc_clr    <= 1'b0;
      bus.acc_en     <= 1'b0;
      bus.acc_idx    <= '0;
      bus.post_start <= 1'b0;
    end else begin
      bus.acc_clr    <= 1'b0;
      bus.acc_en     <= 1'b0;
      bus.post_start <= 1'b0;
      bus.done       <= 1'b0;
      // abort also kills the strobe that would have followed the current read
      if (state != IDLE && bus.abort) begin
        state       <= IDLE;
        bus.busy    <= 1'b0;
        bus.w_rd_en <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              feat        <= bus.features;
              k           <= '0;
              neuron      <= '0;
              bus.w_addr  <= '0;
              bus.acc_clr <= 1'b1;
              bus.busy    <= 1'b1;
              state       <= CLEAR;
            end
          end
          CLEAR: begin
            bus.w_rd_en <= 1'b1;
            state       <= RUN;
          end
          RUN: begin
            bus.acc_en  <= feat[k];
            bus.acc_idx <= neuron;
            if (bus.w_addr == LAST_ADDR) begin
              bus.w_rd_en <= 1'b0;
              state       <= DRAIN;
            end else begin
              bus.w_addr <= bus.w_addr + ADDR_W'(1);
              if (k == K_LAST) begin
                k      <= '0;
                neuron <= neuron + NIDX_W'(1);
              end else begin
                k <= k + K_W'(1);
              end
            end
          end
          DRAIN: begin
            bus.post_start <= 1'b1;
            state          <= POST;
          end
          POST: begin
            if (bus.post_done) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
          DONE: begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            bus.busy    <= 1'b0;
            bus.w_rd_en <= 1'b0;
            state       <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nn_l1_sequencer.sv
// Scoreboard bench: stimulus pushes expected strobe events, a negedge monitor pops and compares.
module tb_nn_l1_sequencer;
  localparam int N_IN = 784;
  localparam int N_HID = 64;
  localparam int ADDR_W = 16;
  localparam int NIDX_W = 6;

  localparam int K_CLR = 0;
  localparam int K_ACC = 1;
  localparam int K_POST = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int cyc;
    int idx;
  } ev_t;

  logic ACLK;
  logic ARESETN;
  int   cyc;
  int   job_base;
  int   n_chk;
  int   n_err;
  ev_t  exp_q[$];

  nn_l1_sequencer_if #(.N_IN(N_IN), .ADDR_W(ADDR_W), .NIDX_W(NIDX_W)) bus ();

  nn_l1_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .ADDR_W(ADDR_W), .NIDX_W(NIDX_W)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int idx);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  // Expected strobes of a job whose start is sampled in cycle c0; events later than lim are dropped.
  task automatic push_job(input int c0, input logic [N_IN-1:0] f, input int lim,
                          input bit full, input int done_cyc);
    push(K_CLR, c0 + 1, 0);
    for (int n = 0; n < N_HID; n++)
      for (int kk = 0; kk < N_IN; kk++)
        if (f[kk] && (c0 + 3 + n * N_IN + kk) <= lim)
          push(K_ACC, c0 + 3 + n * N_IN + kk, n);
    if (full) begin
      push(K_POST, c0 + 50179, 0);
      push(K_DONE, done_cyc, 0);
    end
  endtask

  task automatic see_event(input int kind, input int idx);
    n_chk++;
    if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].kind != kind) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d idx %0d at cycle %0d, expected next kind %0d at cycle %0d",
               kind, idx, cyc, (exp_q.size() > 0) ? exp_q[0].kind : -1,
               (exp_q.size() > 0) ? exp_q[0].cyc : -1);
    end else begin
      if (exp_q[0].idx != idx) begin
        n_err++;
        $display("FAIL acc_idx: got %0d expected %0d at cycle %0d", idx, exp_q[0].idx, cyc);
      end
      void'(exp_q.pop_front());
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESETN) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_chk++;
        n_err++;
        $display("FAIL missing_event: kind %0d expected at cycle %0d, not seen by cycle %0d",
                 exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (bus.acc_clr)    see_event(K_CLR, 0);
      if (bus.acc_en)     see_event(K_ACC, int'(bus.acc_idx));
      if (bus.post_start) see_event(K_POST, 0);
      if (bus.done)       see_event(K_DONE, 0);
      if (bus.w_rd_en)    chk("w_addr", int'(bus.w_addr), cyc - job_base - 2);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},       int'(bus.busy), 0);
    chk({tag, "_done"},       int'(bus.done), 0);
    chk({tag, "_w_rd_en"},    int'(bus.w_rd_en), 0);
    chk({tag, "_acc_clr"},    int'(bus.acc_clr), 0);
    chk({tag, "_acc_en"},     int'(bus.acc_en), 0);
    chk({tag, "_post_start"}, int'(bus.post_start), 0);
    chk({tag, "_w_addr"},     int'(bus.w_addr), 0);
    chk({tag, "_acc_idx"},    int'(bus.acc_idx), 0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge ACLK);
  endtask

  initial begin
    logic [N_IN-1:0] f3;
    logic [N_IN-1:0] f5;
    int c0;
    int c1;
    int c2;
    n_chk = 0;
    n_err = 0;
    job_base = 0;
    f3 = '0;
    f3[0] = 1'b1;
    f3[5] = 1'b1;
    f3[783] = 1'b1;
    f5 = '0;
    f5[5] = 1'b1;
    ARESETN = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.features = '0;
    bus.post_done = 1'b0;
    repeat (3) @(negedge ACLK);
    chk_all_zero("reset");
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Job A: reset asserted at cycle 1000 of the job
    c0 = cyc;
    job_base = c0;
    push_job(c0, f3, c0 + 1000, 1'b0, 0);
    bus.features = f3;
    bus.start = 1'b1;
    @(negedge ACLK);
    bus.start = 1'b0;
    chk("jobA_busy_c1", int'(bus.busy), 1);
    wait_cyc(c0 + 1000);
    #1 ARESETN = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("jobA_queue_empty", exp_q.size(), 0);

    // Job B: start together with abort (start wins), then abort at cycle 2000
    c1 = cyc;
    job_base = c1;
    push_job(c1, f5, c1 + 2000, 1'b0, 0);
    bus.features = f5;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge ACLK);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    wait_cyc(c1 + 2000);
    chk("jobB_busy_before_abort", int'(bus.busy), 1);
    bus.abort = 1'b1;
    @(negedge ACLK);
    bus.abort = 1'b0;
    chk("jobB_busy_after_abort", int'(bus.busy), 0);
    chk("jobB_rd_en_after_abort", int'(bus.w_rd_en), 0);
    repeat (10) @(negedge ACLK);
    chk("jobB_queue_empty", exp_q.size(), 0);

    // Job C: full walk, post_done low for 100 POST cycles, stray start pulses ignored
    c2 = cyc;
    job_base = c2;
    push_job(c2, f3, c2 + 50178, 1'b1, c2 + 50280);
    bus.features = f3;
    bus.start = 1'b1;
    @(negedge ACLK);
    bus.start = 1'b0;
    bus.features = '1;
    chk("jobC_busy_c1", int'(bus.busy), 1);
    wait_cyc(c2 + 100);
    bus.start = 1'b1;
    @(negedge ACLK);
    bus.start = 1'b0;
    wait_cyc(c2 + 40000);
    bus.start = 1'b1;
    @(negedge ACLK);
    bus.start = 1'b0;
    wait_cyc(c2 + 50178);
    chk("jobC_drain_rd_en", int'(bus.w_rd_en), 0);
    chk("jobC_drain_busy", int'(bus.busy), 1);
    wait_cyc(c2 + 50200);
    bus.start = 1'b1;
    @(negedge ACLK);
    bus.start = 1'b0;
    wait_cyc(c2 + 50279);
    bus.post_done = 1'b1;
    @(negedge ACLK);
    bus.post_done = 1'b0;
    chk("jobC_busy_at_done", int'(bus.busy), 1);
    @(negedge ACLK);
    chk("jobC_busy_after_done", int'(bus.busy), 0);
    repeat (5) @(negedge ACLK);
    chk("jobC_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
